// File: rtl/popcount_seq.sv
// Word popcount built on an external registered 4-bit counting stage: nibbles go out one per
// cycle, returning counts are accumulated. Define POPCOUNT_SEQ_BYPASS_EN to short-cut all-0/all-1 words.
module popcount_seq #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  input  logic          i_VALID,
  output logic          o_READY,
  input  logic [WIDTH-1:0] i_DATA,
  input  logic          i_INVERSE,
  output logic [3:0]    o_NIBBLE,
  output logic          o_NIBBLE_INVERSE,
  input  logic [2:0]    i_NIBBLE_COUNT,
  output logic          o_VALID,
  input  logic          i_READY,
  output logic [CW-1:0] o_COUNT
);

  localparam int N  = WIDTH / 4;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LAT-1:0] TAG_TOP = LAT'(1) << (LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              ready_q, valid_q, inv_q, nib_vld_q;
  logic [3:0]        nibble_q;
  logic [RW-1:0]     rem_q;
  logic [LAT-1:0]    tag_q;
  logic [WIDTH-1:0]  data_sh;
  logic [CW-1:0]     acc, count_q;
  logic              accept, bypass_hit, tag_out, last_tag;

  // Result for a uniform word: ones-count is WIDTH or 0, swapped when counting zeros.
  function automatic logic [CW-1:0] flat_count(input logic ones, input logic inv);
    return (ones ^ inv) ? CW'(WIDTH) : '0;
  endfunction

  assign accept = i_VALID && ready_q;

`ifdef POPCOUNT_SEQ_BYPASS_EN
  assign bypass_hit = (i_DATA == '0) || (i_DATA == '1);
`else
  assign bypass_hit = 1'b0;
`endif

  // The last in-flight nibble is the only tag left, sitting at the exit.
  assign tag_out  = tag_q[LAT-1];
  assign last_tag = (tag_q == TAG_TOP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bypass_hit ? DONE : ISSUE;
      ISSUE:   if (rem_q == '0) state_d = DRAIN;
      DRAIN:   if (last_tag) state_d = DONE;
      DONE:    if (valid_q && i_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      inv_q     <= 1'b0;
      nib_vld_q <= 1'b0;
      nibble_q  <= '0;
      rem_q     <= '0;
      tag_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      // A bypassed word spends one cycle in DONE before o_VALID rises.
      valid_q <= (state_d == DONE) && (state_q != IDLE);

      nibble_q  <= '0;
      nib_vld_q <= 1'b0;
      if (accept && !bypass_hit) begin
        nibble_q  <= i_DATA[3:0];
        nib_vld_q <= 1'b1;
        rem_q     <= RW'(N - 1);
      end else if (state_q == ISSUE && rem_q != '0) begin
        nibble_q  <= data_sh[3:0];
        nib_vld_q <= 1'b1;
        rem_q     <= rem_q - RW'(1);
      end

      // The stage samples inverse one cycle after the nibble, so hold it through DRAIN.
      if (state_d == ISSUE || state_d == DRAIN)
        inv_q <= accept ? i_INVERSE : inv_q;
      else
        inv_q <= 1'b0;

      tag_q <= (tag_q << 1) | LAT'(nib_vld_q);

      if (state_q == DRAIN && last_tag)
        count_q <= acc + CW'(i_NIBBLE_COUNT);
      else if (state_q == DONE && !valid_q)
        count_q <= acc;
    end
  end

  // ---- data path: word shifter and accumulator (no reset, cleared on accept) ----
  always_ff @(posedge i_CLK) begin
    if (accept)
      data_sh <= i_DATA >> 4;
    else if (state_q == ISSUE)
      data_sh <= data_sh >> 4;

    if (accept)
      acc <= bypass_hit ? flat_count(i_DATA[0], i_INVERSE) : '0;
    else if (tag_out)
      acc <= acc + CW'(i_NIBBLE_COUNT);
  end

  assign o_READY          = ready_q;
  assign o_VALID          = valid_q;
  assign o_COUNT          = count_q;
  assign o_NIBBLE         = nibble_q;
  assign o_NIBBLE_INVERSE = inv_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: models the registered 4-bit counting stage, pushes hand-computed
// results into a scoreboard and checks them from an independent output monitor.
module tb_popcount_seq;

`ifdef POPCOUNT_SEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [15:0] data = '0;
  logic        inverse = 1'b0;
  logic [3:0]  nibble;
  logic        nibble_inv;
  logic [2:0]  nibble_count;
  logic        out_valid;
  logic        down_ready = 1'b1;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [4:0] cnt;
    int         lat;
    int         t0;
  } exp_t;
  exp_t sb[$];

  popcount_seq #(.WIDTH(16), .LAT(2)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(in_valid), .o_READY(out_ready),
    .i_DATA(data), .i_INVERSE(inverse), .o_NIBBLE(nibble),
    .o_NIBBLE_INVERSE(nibble_inv), .i_NIBBLE_COUNT(nibble_count),
    .o_VALID(out_valid), .i_READY(down_ready), .o_COUNT(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-bit stage: registers the nibble, then counts it with the inverse seen one cycle later.
  logic [3:0] stg_nib = '0;
  logic [2:0] stg_cnt = '0;
  function automatic logic [2:0] nib_pop(input logic [3:0] n, input logic inv);
    logic [2:0] c;
    c = 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
    return inv ? 3'(4 - c) : c;
  endfunction
  always @(posedge clk) begin
    stg_nib <= nibble;
    stg_cnt <= nib_pop(stg_nib, nibble_inv);
  end
  assign nibble_count = stg_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares each new result's value and latency against the queue head.
  logic vld_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !vld_seen) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_count", 32'(count), 32'(e.cnt));
        chk("sb_latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
    vld_seen <= out_valid;
  end

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_ready) return;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic inv, input logic [4:0] exp_cnt);
    exp_t e;
    logic byp;
    int   lat;
    logic [3:0] en;
    byp = BYP && (d == 16'h0000 || d == 16'hFFFF);
    lat = byp ? 1 : 6;
    wait_ready();
    in_valid = 1'b1;
    data     = d;
    inverse  = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data     = '0;
    inverse  = 1'b0;
    e.cnt = exp_cnt;
    e.lat = lat;
    e.t0  = cyc;
    sb.push_back(e);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      en = (byp || k >= 4) ? 4'h0 : d[4*k +: 4];
      chk($sformatf("nibble_k%0d", k), 32'(nibble), 32'(en));
      chk($sformatf("nib_inv_k%0d", k), 32'(nibble_inv), 32'((!byp && k < 6) ? inv : 1'b0));
      chk($sformatf("ready_busy_k%0d", k), 32'(out_ready), 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(out_ready), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_nibble"}, 32'(nibble), 0);
    chk({tag, "_nib_inv"}, 32'(nibble_inv), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(out_ready), 0);
    @(posedge clk);
    #1;
    chk("ready_first_edge", 32'(out_ready), 1);

    send(16'hF0A5, 1'b0, 5'd8);
    send(16'h8001, 1'b0, 5'd2);
    send(16'h8001, 1'b1, 5'd14);
    send(16'h1234, 1'b0, 5'd5);
    send(16'h0000, 1'b0, 5'd0);
    send(16'h0000, 1'b1, 5'd16);
    send(16'hFFFF, 1'b1, 5'd0);

    // Back-pressure: result must hold while downstream stalls.
    wait_ready();
    down_ready = 1'b0;
    send(16'h7E11, 1'b0, 5'd8);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("hold_valid_seen", 32'(out_valid), 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_count", 32'(count), 8);
      chk("hold_ready", 32'(out_ready), 0);
    end
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_ready", 32'(out_ready), 1);
    chk("handoff_valid", 32'(out_valid), 0);
    chk("handoff_count_kept", 32'(count), 8);

    // Asynchronous reset in the middle of ISSUE discards the word.
    wait_ready();
    in_valid = 1'b1;
    data     = 16'hF0A5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data     = '0;
    @(negedge clk);
    chk("abort_nibble0", 32'(nibble), 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;

    send(16'hFFFF, 1'b0, 5'd16);
    repeat (10) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
